// File: rtl/sha3_pad_absorb_if.sv
// rtl/sha3_pad_absorb_if.sv - message stream and Keccak block handshake bundle for sha3_pad_absorb
//
// Purpose: groups the message-side AXI-Stream signals and the block-side
// handshake to the Keccak permutation core into one bundle.
//
// Signals:
//   S_TDATA     DATA_WIDTH  message word, S_TDATA[7:0] is the first byte
//   S_TVALID    1           word valid
//   S_TREADY    1           word accepted when S_TVALID & S_TREADY
//   S_TLAST     1           final word of message
//   S_TID       2           hash select 0..3 = SHA3-224/256/384/512
//   Block       1600        assembled block, lane i at [64i+63:64i]
//   Block_valid 1           Block, Block_last, Block_TID valid
//   Block_ready 1           core accepts block
//   Block_last  1           final block of its message
//   Block_TID   2           hash select latched for the message
//
// Modports:
//   master  host / core side (drives the message, accepts blocks)
//   slave   sha3_pad_absorb side
interface sha3_pad_absorb_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] S_TDATA;
  logic                  S_TVALID;
  logic                  S_TREADY;
  logic                  S_TLAST;
  logic [1:0]            S_TID;

  logic [1599:0]         Block;
  logic                  Block_valid;
  logic                  Block_ready;
  logic                  Block_last;
  logic [1:0]            Block_TID;

  modport master (
    output S_TDATA, S_TVALID, S_TLAST, S_TID,
    input  S_TREADY,
    input  Block, Block_valid, Block_last, Block_TID,
    output Block_ready
  );

  modport slave (
    input  S_TDATA, S_TVALID, S_TLAST, S_TID,
    output S_TREADY,
    output Block, Block_valid, Block_last, Block_TID,
    input  Block_ready
  );
endinterface

// File: rtl/sha3_pad_absorb.sv
// rtl/sha3_pad_absorb.sv - SHA-3 input stage: word packing, multi-rate padding, block handoff
//
// Purpose: packs DATA_WIDTH-bit message words into rate-sized blocks,
// appends SHA-3 padding (0x06 ... 0x80) and presents each 1600-bit block,
// capacity bits zero, to the Keccak permutation core.
//
// Parameters:
//   DATA_WIDTH  stream word width, one of 8, 16, 32, 64
//
// Ports:
//   ACLK     in  clock, all logic on the rising edge
//   ARESETn  in  synchronous active-low reset
//   bus      sha3_pad_absorb_if.slave (S_* message stream, Block* output)
//
// Optional feature macro:
//   SHA3_BYTE_SWAP_EN  reverse the bytes of each incoming word so that
//                      S_TDATA[DATA_WIDTH-1 -: 8] is the first message byte
//                      (big-endian hosts). Padding placement is unchanged.
module sha3_pad_absorb #(
  parameter int DATA_WIDTH = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  sha3_pad_absorb_if.slave  bus
);

  // Index of the last word in a block for each hash select (W-1).
  localparam logic [7:0] LAST_IDX_224 = 8'(1152 / DATA_WIDTH - 1);
  localparam logic [7:0] LAST_IDX_256 = 8'(1088 / DATA_WIDTH - 1);
  localparam logic [7:0] LAST_IDX_384 = 8'(832  / DATA_WIDTH - 1);
  localparam logic [7:0] LAST_IDX_512 = 8'(576  / DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic          pad_first;    // next PAD word carries the 0x06 domain byte
  logic          pad_pending;  // message ended exactly on a block boundary
  logic          msg_start;    // next accepted beat is the first of a message
  logic [1:0]    tid_q;        // hash select latched for the current message
  logic [1599:0] blk;
  logic          blk_valid;
  logic          blk_last;
  logic [1:0]    blk_tid;

  logic [1:0]    cur_tid;
  logic [7:0]    fill_last_idx;
  logic [7:0]    pad_last_idx;
  logic [10:0]   wr_base;
  logic          pad_at_end;

  function automatic logic [7:0] last_idx(input logic [1:0] tid);
    logic [7:0] r;
    case (tid)
      2'd0:    r = LAST_IDX_224;
      2'd1:    r = LAST_IDX_256;
      2'd2:    r = LAST_IDX_384;
      default: r = LAST_IDX_512;
    endcase
    return r;
  endfunction

  // Puts the first message byte of a word into bits [7:0].
  function automatic logic [DATA_WIDTH-1:0] order_bytes(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
`ifdef SHA3_BYTE_SWAP_EN
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      r[8*i +: 8] = d[DATA_WIDTH-8-8*i +: 8];
    end
`else
    r = d;
`endif
    return r;
  endfunction

  // Padding word: 0x06 in the first byte when the message ended in the
  // previous slot, 0x80 ORed into the final byte of the last slot. At
  // DATA_WIDTH=8 both may land in the same byte, giving 0x86.
  function automatic logic [DATA_WIDTH-1:0] pad_word(input logic first, input logic last);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    if (first) begin
      w[7:0] = 8'h06;
    end
    if (last) begin
      w[DATA_WIDTH-1 -: 8] = w[DATA_WIDTH-1 -: 8] | 8'h80;
    end
    return w;
  endfunction

  // On the first beat of a message S_TID is live; afterwards the latched copy
  // decides the block length, so a host changing S_TID mid-message is ignored.
  assign cur_tid       = msg_start ? bus.S_TID : tid_q;
  assign fill_last_idx = last_idx(cur_tid);
  assign pad_last_idx  = last_idx(tid_q);
  assign pad_at_end    = (cnt == pad_last_idx);
  assign wr_base       = 11'(cnt) * 11'(DATA_WIDTH);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= ST_FILL;
      cnt         <= 8'd0;
      pad_first   <= 1'b0;
      pad_pending <= 1'b0;
      msg_start   <= 1'b1;
      tid_q       <= 2'd0;
      blk         <= '0;
      blk_valid   <= 1'b0;
      blk_last    <= 1'b0;
      blk_tid     <= 2'd0;
    end else begin
      case (state)
        ST_FILL: begin
          if (bus.S_TVALID) begin
            blk[wr_base +: DATA_WIDTH] <= order_bytes(bus.S_TDATA);
            if (msg_start) begin
              tid_q <= bus.S_TID;
            end
            msg_start <= bus.S_TLAST;
            if (cnt == fill_last_idx) begin
              // Block full; if the message also ends here, a pad-only block
              // follows after the handoff.
              state       <= ST_HOLD;
              blk_valid   <= 1'b1;
              blk_last    <= 1'b0;
              blk_tid     <= cur_tid;
              pad_pending <= bus.S_TLAST;
            end else begin
              cnt <= cnt + 8'd1;
              if (bus.S_TLAST) begin
                pad_first <= 1'b1;
                state     <= ST_PAD;
              end
            end
          end
        end

        ST_PAD: begin
          blk[wr_base +: DATA_WIDTH] <= blk[wr_base +: DATA_WIDTH]
                                        | pad_word(pad_first, pad_at_end);
          pad_first <= 1'b0;
          if (pad_at_end) begin
            state     <= ST_HOLD;
            blk_valid <= 1'b1;
            blk_last  <= 1'b1;
            blk_tid   <= tid_q;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_HOLD: begin
          if (bus.Block_ready) begin
            // Clearing here keeps unwritten slots and capacity bits at zero
            // for the next block without any per-word masking.
            blk       <= '0;
            cnt       <= 8'd0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            if (pad_pending) begin
              pad_pending <= 1'b0;
              pad_first   <= 1'b1;
              state       <= ST_PAD;
            end else begin
              state <= ST_FILL;
            end
          end
        end

        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  assign bus.S_TREADY    = (state == ST_FILL) && ARESETn;
  assign bus.Block       = blk;
  assign bus.Block_valid = blk_valid;
  assign bus.Block_last  = blk_last;
  assign bus.Block_TID   = blk_tid;

endmodule

// File: tb/tb_sha3_pad_absorb.sv
// tb/tb_sha3_pad_absorb.sv - directed self-checking bench for sha3_pad_absorb at DATA_WIDTH=16
module tb_sha3_pad_absorb;

  localparam int DW = 16;

  logic ACLK;
  logic ARESETn;

  int tests_run;
  int tests_failed;

  sha3_pad_absorb_if #(.DATA_WIDTH(DW)) bus ();

  sha3_pad_absorb #(.DATA_WIDTH(DW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_block(input string tag, input logic [1599:0] exp);
    for (int i = 0; i < 25; i++) begin
      check($sformatf("%s_lane%0d", tag, i), bus.Block[64*i +: 64], exp[64*i +: 64]);
    end
  endtask

  // Expected storage of a message word inside the block.
  function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef SHA3_BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] data, input logic last, input logic [1:0] tid);
    int n;
    bus.S_TDATA  = data;
    bus.S_TLAST  = last;
    bus.S_TID    = tid;
    bus.S_TVALID = 1'b1;
    n = 0;
    while (!bus.S_TREADY && n < 200) begin
      tick();
      n++;
    end
    if (!bus.S_TREADY) check("tready_timeout", 64'(bus.S_TREADY), 64'd1);
    tick();
    bus.S_TVALID = 1'b0;
    bus.S_TLAST  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.Block_valid && n < 300) begin
      tick();
      n++;
    end
    if (!bus.Block_valid) check("valid_timeout", 64'(bus.Block_valid), 64'd1);
  endtask

  task automatic handshake();
    bus.Block_ready = 1'b1;
    tick();
    bus.Block_ready = 1'b0;
  endtask

  logic [1599:0] exp_blk;
  int            lat;

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    ARESETn         = 1'b0;
    bus.S_TDATA     = '0;
    bus.S_TVALID    = 1'b0;
    bus.S_TLAST     = 1'b0;
    bus.S_TID       = 2'd0;
    bus.Block_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_tready", 64'(bus.S_TREADY), 64'd0);
    check("rst_valid",  64'(bus.Block_valid), 64'd0);
    check("rst_last",   64'(bus.Block_last), 64'd0);
    check("rst_tid",    64'(bus.Block_TID), 64'd0);
    check_block("rst_block", '0);
    ARESETn = 1'b1;
    #1;
    check("rel_tready", 64'(bus.S_TREADY), 64'd1);

    // Single-word message, TID=1; Block_ready high while not valid is harmless
    bus.Block_ready = 1'b1;
    send_word(16'h6261, 1'b1, 2'd1);
    check("pad_tready", 64'(bus.S_TREADY), 64'd0);
    repeat (10) tick();
    bus.Block_ready = 1'b0;
    wait_valid(lat);
    check("single_latency", 64'(lat + 10), 64'd67);
    exp_blk = '0;
    exp_blk[15:0]      = stored(16'h6261);
    exp_blk[23:16]     = 8'h06;
    exp_blk[1087:1080] = 8'h80;
    check_block("single", exp_blk);
    check("single_last", 64'(bus.Block_last), 64'd1);
    check("single_tid",  64'(bus.Block_TID), 64'd1);
    handshake();
    check("single_exit_valid",  64'(bus.Block_valid), 64'd0);
    check("single_exit_tready", 64'(bus.S_TREADY), 64'd1);

    // Exact-rate message: 68 words, TID=1
    exp_blk = '0;
    for (int i = 0; i < 68; i++) begin
      send_word(16'h1000 + 16'(i), (i == 67), 2'd1);
      exp_blk[16*i +: 16] = stored(16'h1000 + 16'(i));
    end
    check("exact_valid_now", 64'(bus.Block_valid), 64'd1);
    check_block("exact_data", exp_blk);
    check("exact_data_last", 64'(bus.Block_last), 64'd0);
    handshake();
    wait_valid(lat);
    check("exact_pad_latency", 64'(lat), 64'd68);
    exp_blk = '0;
    exp_blk[7:0]       = 8'h06;
    exp_blk[1087:1080] = 8'h80;
    check_block("exact_pad", exp_blk);
    check("exact_pad_last", 64'(bus.Block_last), 64'd1);
    check("exact_pad_tid",  64'(bus.Block_TID), 64'd1);
    handshake();

    // TLAST in final slot, TID=3 (W=36)
    for (int i = 0; i < 36; i++) begin
      send_word(16'hA500 + 16'(i), (i == 35), 2'd3);
    end
    check("slot_valid_now", 64'(bus.Block_valid), 64'd1);
    check("slot_word35", 64'(bus.Block[575:560]), 64'(stored(16'hA523)));
    check("slot_last", 64'(bus.Block_last), 64'd0);
    check("slot_tid",  64'(bus.Block_TID), 64'd3);
    handshake();
    wait_valid(lat);
    check("slot_pad_latency", 64'(lat), 64'd36);
    exp_blk = '0;
    exp_blk[7:0]     = 8'h06;
    exp_blk[575:568] = 8'h80;
    check_block("slot_pad", exp_blk);
    check("slot_pad_last", 64'(bus.Block_last), 64'd1);
    handshake();

    // 35 words with TLAST, TID=3: one PAD cycle carrying 0x06 and 0x80
    exp_blk = '0;
    for (int i = 0; i < 35; i++) begin
      send_word(16'h3c00 + 16'(i), (i == 34), 2'd3);
      exp_blk[16*i +: 16] = stored(16'h3c00 + 16'(i));
    end
    wait_valid(lat);
    check("w35_latency", 64'(lat), 64'd1);
    exp_blk[567:560] = 8'h06;
    exp_blk[575:568] = 8'h80;
    check_block("w35", exp_blk);
    check("w35_last", 64'(bus.Block_last), 64'd1);
    handshake();

    // Backpressure and TID latch: S_TID moves 1->3 from word 2 on
    exp_blk = '0;
    for (int i = 0; i < 68; i++) begin
      send_word(16'h5a00 + 16'(i), 1'b0, (i >= 2) ? 2'd3 : 2'd1);
      exp_blk[16*i +: 16] = stored(16'h5a00 + 16'(i));
    end
    check("bp_valid_at68", 64'(bus.Block_valid), 64'd1);
    check("bp_tid", 64'(bus.Block_TID), 64'd1);
    bus.S_TVALID = 1'b1;
    bus.S_TDATA  = 16'hdead;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_tready_c%0d", c), 64'(bus.S_TREADY), 64'd0);
      check($sformatf("bp_valid_c%0d", c), 64'(bus.Block_valid), 64'd1);
      check_block($sformatf("bp_hold_c%0d", c), exp_blk);
      tick();
    end
    bus.S_TVALID = 1'b0;
    handshake();
    send_word(16'h0077, 1'b1, 2'd3);
    wait_valid(lat);
    check("bp_tail_latency", 64'(lat), 64'd67);
    exp_blk = '0;
    exp_blk[15:0]      = stored(16'h0077);
    exp_blk[23:16]     = 8'h06;
    exp_blk[1087:1080] = 8'h80;
    check_block("bp_tail", exp_blk);
    check("bp_tail_tid",  64'(bus.Block_TID), 64'd1);
    check("bp_tail_last", 64'(bus.Block_last), 64'd1);
    handshake();

    // Reset mid-block after 20 words of a TID=2 message
    for (int i = 0; i < 20; i++) begin
      send_word(16'hffff - 16'(i), 1'b0, 2'd2);
    end
    ARESETn = 1'b0;
    tick();
    check("midrst_valid",  64'(bus.Block_valid), 64'd0);
    check("midrst_tready", 64'(bus.S_TREADY), 64'd0);
    tick();
    ARESETn = 1'b1;
    #1;
    send_word(16'hbeef, 1'b1, 2'd0);
    wait_valid(lat);
    check("midrst_latency", 64'(lat), 64'd71);
    exp_blk = '0;
    exp_blk[15:0]      = stored(16'hbeef);
    exp_blk[23:16]     = 8'h06;
    exp_blk[1151:1144] = 8'h80;
    check_block("midrst", exp_blk);
    check("midrst_tid",  64'(bus.Block_TID), 64'd0);
    check("midrst_last", 64'(bus.Block_last), 64'd1);
    handshake();

    // Byte order of stored words
    send_word(16'h6162, 1'b1, 2'd1);
    wait_valid(lat);
`ifdef SHA3_BYTE_SWAP_EN
    check("swap_word0", 64'(bus.Block[15:0]), 64'h6261);
`else
    check("swap_word0", 64'(bus.Block[15:0]), 64'h6162);
`endif
    check("swap_pad", 64'(bus.Block[23:16]), 64'h06);
    check("swap_end", 64'(bus.Block[1087:1080]), 64'h80);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sha3_pad_absorb.md
# sha3_pad_absorb

Input stage of the SHA-3 datapath. It accepts a message as an AXI-Stream of DATA_WIDTH-bit words and assembles rate-sized blocks. It applies SHA-3 multi-rate padding (0x06…0x80) and hands each 1600-bit block, with capacity bits zero, to the Keccak permutation core. The output-mode serializer sits downstream of that core.

## Interface
- DATA_WIDTH, 16: stream word width; legal values 8, 16, 32, 64.
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- S_TDATA  in  DATA_WIDTH  message word.
- S_TVALID  in  1  word valid.
- S_TREADY  out  1  word accepted when S_TVALID & S_TREADY.
- S_TLAST  in  1  final word of message.
- S_TID  in  2  hash select: 0=SHA3-224, 1=256, 2=384, 3=512.
- Block  out  1600  block; lane i at bits [64i+63:64i]; bits above rate are 0.
- Block_valid  out  1  Block, Block_last and Block_TID are valid.
- Block_ready  in  1  core accepts block when Block_valid & Block_ready.
- Block_last  out  1  block is the final block of its message.
- Block_TID  out  2  S_TID latched for the message.

## Operation
- Rate r = 1152/1088/832/576 bits for TID 0..3. Words per block W = r/DATA_WIDTH, giving 72/68/52/36 at DATA_WIDTH 16.
- S_TID is latched on the first beat of a message (first beat after reset or after a TLAST beat). It is ignored on later beats.
- Word k of a block occupies Block[DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]. S_TDATA[7:0] is the first message byte.
- State machine: FILL, PAD, HOLD. Word counter cnt has 8 bits.
- **FILL**
  - S_TREADY=1. Each beat writes word cnt.
  - TLAST with cnt<W-1: cnt+1, set pad_first, go to PAD.
  - TLAST with cnt==W-1: set pad_pending, go to HOLD with Block_last=0.
  - No TLAST with cnt==W-1: go to HOLD with Block_last=0.
  - Otherwise: cnt+1.
- **PAD**
  - S_TREADY=0. One word is written per cycle at cnt.
  - Its first byte is 0x06 if pad_first; pad_first then clears.
  - At cnt==W-1, the word's last byte is ORed with 0x80 (0x86 when both apply at DATA_WIDTH=8). The block then goes to HOLD with Block_last=1.
- **HOLD**
  - S_TREADY=0; Block_valid=1. Block, Block_last and Block_TID are stable.
  - On Block_ready: zero the whole buffer, cnt=0.
  - If pad_pending: clear it, set pad_first, go to PAD. Otherwise go to FILL.
- Buffer is zeroed on every HOLD exit, so unwritten and capacity bits are 0.
- Empty messages are not supported; a message is at least one word.

## Timing
- **Reset values:** state=FILL, cnt=0, pad flags=0, Block=0, Block_valid=0, Block_last=0, Block_TID=0. S_TREADY=0 while ARESETn=0 and 1 in the first cycle after release.
- S_TREADY is combinational from state (FILL and not in reset). Block_valid is registered.
- **Full block without TLAST:** Block_valid rises the cycle after the beat that writes word W-1.
- **TLAST at word j<W-1:** PAD takes W-1-j cycles. Block_valid rises the cycle after the last PAD write.
- **Back-to-back:** FILL resumes the cycle after the HOLD handshake; there is no bubble beyond that.
- **Reset mid-operation:** partial block, flags and latched TID are discarded. Block_valid=0 from the next edge.
- Block_ready held high while Block_valid=0 has no effect.

## Configuration
- SHA3_BYTE_SWAP_EN
  - Defined: the bytes of each S_TDATA word are reversed before storage, so S_TDATA[DATA_WIDTH-1:DATA_WIDTH-8] is the first message byte. This is for big-endian hosts.
  - Undefined: words are stored as received, with S_TDATA[7:0] first.
  - Padding placement is identical in both cases.

## Test plan
- **Single-word message.** DATA_WIDTH=16, TID=1, S_TDATA=0x6261 with TLAST. Required:
  - Block[15:0]=0x6261, Block[23:16]=0x06, Block[1087:1080]=0x80, all other bits 0.
  - Block_last=1, Block_TID=1.
  - Block_valid rises 67 cycles after the cycle following the accepting edge.
- **Exact-rate message.** TID=1, 68 words with TLAST on the 68th. Required:
  - First block holds the data with Block_last=0.
  - After the handshake, second block has Block[7:0]=0x06, Block[1087:1080]=0x80, all else 0, Block_last=1.
- **TLAST in final slot.** TID=3, 36 words with TLAST on word 35. Required: Block[575:560] holds word 35, no PAD cycles, a second pad-only block follows. Then 35 words with TLAST gives Block[567:560]=0x06, Block[575:568]=0x80, Block_last=1.
- **Backpressure and TID latch.**
  - Hold Block_ready=0 for 10 cycles in HOLD. Required: S_TREADY=0 and Block unchanged throughout.
  - Change S_TID 1→3 on word 2 of a message. Required: Block_TID=1 and W=68 are used.
- **Reset mid-block.** Pulse ARESETn low after 20 words. Required: Block_valid=0 and S_TREADY=0 during reset. A following one-word message yields a block with no residue from the aborted words.
- **Byte swap.** With SHA3_BYTE_SWAP_EN defined, send S_TDATA=0x6162 with TLAST, TID=1. Required: Block[15:0]=0x6261, Block[23:16]=0x06.
